smac_noac3_ctrl: RTL

// Sequencer that sits directly upstream of the serial MAC datapath (no-AC3 variant).
// It accepts one job per start handshake and walks the weight bit-planes MSB-first.
// For each weight plane it walks the activation bit-planes MSB-first, driving the plane

---
 rtl/smac_pkg.sv | 23 ++
 rtl/smac_tail_pipe.sv | 25 ++
 rtl/smac_noac3_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/smac_pkg.sv
// Shared types for the serial MAC (no-AC3) sequencer: FSM states and tail pipeline tag.
package smac_pkg;

  // Number of tail stages between the A cycle and the ac2 write.
  localparam int unsigned TAIL_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOADW = 2'd1,
    ACT   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Tag carried down the tail pipeline for every fired A cycle.
  typedef struct packed {
    logic valid;
    logic first_of_plane;
    logic last_of_plane;
    logic msb_w;
    logic first_of_job;
  } tail_tag_t;

endpackage

// File: rtl/smac_tail_pipe.sv
// Fixed-latency delay line for tail tags; stage i holds the tag fired i+1 cycles ago.
module smac_tail_pipe
  import smac_pkg::*;
#(
  parameter int unsigned DEPTH = TAIL_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  tail_tag_t             tag_in,
  output tail_tag_t [DEPTH-1:0] stg
);

  // Shift every cycle; bubbles enter as all-zero (invalid) tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else begin
      stg[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

endmodule

// File: rtl/smac_noac3_ctrl.sv
// Job sequencer for the serial MAC datapath: walks weight planes then activation planes
// MSB-first, stalls on op_valid, and aligns the ac1/neg/ac2 strobes through a tag pipeline.
module smac_noac3_ctrl
  import smac_pkg::*;
#(
  parameter  int unsigned Pa = 8,
  parameter  int unsigned Pw = 4,
  localparam int unsigned AW = $clog2(Pa),
  localparam int unsigned WW = $clog2(Pw)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          ready,
  output logic          busy,
  output logic          done,
  input  logic          op_valid,
  output logic [WW-1:0] wei_bit,
  output logic [AW-1:0] act_bit,
  output logic          we_w,
  output logic          we_br,
  output logic          MSB_a,
  output logic          we_ac1,
  output logic          cl_en_ac1,
  output logic          we_neg,
  output logic          MSB_w,
  output logic          we_ac2,
  output logic          cl_en_ac2
);

  state_t        state_q, state_d;
  logic [WW-1:0] wei_q, wei_d;
  logic [AW-1:0] act_q, act_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          w_fire;
  logic          a_fire;
  logic          tail_pending;
  tail_tag_t     tag_in;
  tail_tag_t [TAIL_DEPTH-1:0] tail_stg;

  // W and A cycles only happen when the operand plane is present.
  assign w_fire = (state_q == LOADW) && op_valid;
  assign a_fire = (state_q == ACT) && op_valid;

  // Anything still in flight that will not have left the tail after this edge.
  always_comb begin
    tail_pending = 1'b0;
    for (int unsigned i = 0; i < TAIL_DEPTH - 1; i++) begin
      tail_pending = tail_pending | tail_stg[i].valid;
    end
  end

  // State, index counters and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wei_q   <= '0;
      act_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wei_q   <= wei_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counter logic; stalled cycles hold everything.
  always_comb begin
    state_d = state_q;
    wei_d   = wei_q;
    act_d   = act_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOADW;
          wei_d   = WW'(Pw - 1);
          busy_d  = 1'b1;
        end
      end
      LOADW: begin
        if (op_valid) begin
          state_d = ACT;
          act_d   = AW'(Pa - 1);
        end
      end
      ACT: begin
        if (op_valid) begin
          if (act_q == '0) begin
            if (wei_q != '0) begin
              wei_d   = wei_q - WW'(1);
              state_d = LOADW;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            act_d = act_q - AW'(1);
          end
        end
      end
      DRAIN: begin
        if (!tail_pending) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag describing the popcount captured in this A cycle.
  always_comb begin
    tag_in = '0;
    if (a_fire) begin
      tag_in.valid          = 1'b1;
      tag_in.first_of_plane = (act_q == AW'(Pa - 1));
      tag_in.last_of_plane  = (act_q == '0);
      tag_in.msb_w          = (wei_q == WW'(Pw - 1));
      tag_in.first_of_job   = (wei_q == WW'(Pw - 1));
    end
  end

  smac_tail_pipe #(
    .DEPTH (TAIL_DEPTH)
  ) u_tail (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (tag_in),
    .stg    (tail_stg)
  );

  // Tag fields that a given stage has no use for.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{tail_stg[0].last_of_plane, tail_stg[0].msb_w,
                             tail_stg[0].first_of_job, tail_stg[1].first_of_plane,
                             tail_stg[1].first_of_job, tail_stg[2].first_of_plane,
                             tail_stg[2].msb_w};

  assign ready   = ~busy_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign wei_bit = wei_q;
  assign act_bit = act_q;

  // Front strobes follow the operand handshake in the same cycle.
  assign we_w  = w_fire;
  assign we_br = a_fire;
  assign MSB_a = a_fire && (act_q == AW'(Pa - 1));

  // Tail strobes decode straight from the stage registers.
  assign we_ac1    = tail_stg[0].valid;
  assign cl_en_ac1 = tail_stg[0].valid & tail_stg[0].first_of_plane;
  assign we_neg    = tail_stg[1].valid & tail_stg[1].last_of_plane;
  assign MSB_w     = tail_stg[1].valid & tail_stg[1].last_of_plane & tail_stg[1].msb_w;
  assign we_ac2    = tail_stg[2].valid & tail_stg[2].last_of_plane;
  assign cl_en_ac2 = tail_stg[2].valid & tail_stg[2].last_of_plane & tail_stg[2].first_of_job;

endmodule
